ai_av_regfile: RTL and testbench
================================

Name: ai_av_regfile

Overview:
Parametrised Avalon-MM slave register file. It configures and launches CHANNELS independent comparer engines, and is the successor to the single-channel write-only comparer configuration slave.
- Adds per-channel register banks, a busy/done handshake with each engine and full read-back with fixed 1-cycle read latency.
- Sits between the Nios/Avalon interconnect and the comparer array. Each engine gets its own init pulse and a stable configuration bus.

Parameters:
CHANNELS, 4, number of comparer engines (1..16)
ADDR_W, 6, Avalon word-address width; must be >= clog2(CHANNELS)+3
SECTOR_W, 16, width of load_sector / load_len per channel
MAX_W, 24, width of max threshold per channel
SCORE_W, 16, width of engine result score

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
avs_s0_write  in  1  Avalon write strobe
avs_s0_read  in  1  Avalon read strobe
avs_s0_address  in  ADDR_W  word address; [ADDR_W-1:3] = channel, [2:0] = register
avs_s0_writedata  in  32  write data
avs_s0_readdata  out  32  read data, valid with readdatavalid
avs_s0_readdatavalid  out  1  1-cycle pulse, one per accepted read
init  out  CHANNELS  per-channel 1-cycle start pulse
load_sector  out  CHANNELS*SECTOR_W  per-channel start sector, flattened, ch0 in LSBs
load_len  out  CHANNELS*SECTOR_W  per-channel length
score_minimum  out  CHANNELS*8  per-channel minimum score
sample_size  out  CHANNELS*15  per-channel sample size
packet_size  out  CHANNELS*8  per-channel packet size
max  out  CHANNELS*MAX_W  per-channel max threshold
compress  out  CHANNELS  per-channel compress mode
done_i  in  CHANNELS  engine completion pulse
score_i  in  CHANNELS*SCORE_W  engine score, valid while done_i is high

Behaviour:
Reset: all outputs, all registers and busy/err/done flags are 0. Reset is asserted asynchronously and released on the clk edge. A rst assertion mid-run clears busy immediately; an engine still running is not signalled.

Register map, per channel (reg index):
- 0 START
  - Write: load_sector <= wd[31:16], load_len <= wd[15:0]; init[ch] pulses high for exactly the next cycle.
  - Read: {29'b0, err, done, busy}.
- 1 SCORE_MIN: wd[7:0]
- 2 SIZES: sample_size = wd[14:0], packet_size = wd[23:16]
- 3 MAX: wd[MAX_W-1:0]
- 4 CTRL: bit0 compress, bit1 irq_en
- 5 RESULT: read-only, last latched score_i, zero-extended
- 6 FLAGS: write-1-to-clear; bit1 clears done, bit2 clears err
- 7: reserved; reads 0, writes ignored

Configuration outputs hold their values (not zeroed between writes). They change only on a register write or reset.

START handshake:
- A START write while busy[ch]=0 sets busy, latches sector/len and pulses init.
- A START write while busy[ch]=1 is rejected: no init pulse, sector/len unchanged, err[ch] set.
- done_i[ch]: busy <= 0, done <= 1, RESULT <= score_i slice.

Busy is sampled before the done update. A START write in the same cycle as done_i is therefore rejected (err set) and done is still recorded. Flag set wins over a same-cycle W1C clear.

Writes to a channel index >= CHANNELS are ignored. Reads of such an index return 0 and still produce readdatavalid.

Read path:
- readdata is registered; readdatavalid is high the cycle after avs_s0_read.
- Reads return current register contents; SIZES reads back {packet_size, 1'b0, sample_size}.
- Reads in consecutive cycles are fully pipelined.
- A write and a read in the same cycle are both serviced. The read returns the pre-write value.

Optional Feature:
AI_AV_IRQ_EN:
- Defined: adds output irq (1 bit, registered) = OR over ch of (done[ch] & irq_en[ch]). It deasserts the cycle after the last contributing done is cleared.
- Undefined: no irq port; CTRL bit1 is reserved and reads 0.

Decomposition:
Shared package ai_av_pkg holds:
- register index constants REG_START..REG_FLAGS
- flag bit positions BUSY_B, DONE_B, ERR_B
- CTRL bit positions
- channel-config struct typedef (sector, len, score_min, sample_size, packet_size, max, compress, irq_en)

One natural sub-module, ai_av_channel_regs: a single channel's registers, flags and init logic. It is generated CHANNELS times. The top level holds address decode and the read mux/register.

Test Plan:
- Reset, then read ch0 regs 0..6 -> all readdata 0, readdatavalid exactly 1 cycle after each read.
- Write ch2 START 0x0012_0040 -> init=4'b0100 for one cycle; sector slice=0x12, len=0x40; ch2 STATUS reads 0x1.
- While ch2 busy, write START 0x0099_0001 -> no init; slice stays 0x12/0x40; STATUS reads 0x5.
- Pulse done_i[2] with score 0x1234 -> STATUS=0x6 (done|err), RESULT=0x1234; write FLAGS 0x6 -> STATUS=0.
- Write SIZES 0x0020_7FFF to ch1; same-cycle write+read on ch1 reg2 -> read returns old 0; next read returns 0x0020_7FFF.
- With AI_AV_IRQ_EN: set ch3 irq_en, pulse done_i[3] -> irq=1; W1C done -> irq=0 the next cycle. Address for ch index 5 with CHANNELS=4 -> write ignored, read returns 0.

Source files
------------

// File: rtl/ai_av_pkg.sv
// Shared definitions for the ai_av comparer register file: register indices, flag/CTRL bit
// positions and the per-channel configuration record.
package ai_av_pkg;

  localparam logic [2:0] REG_START     = 3'd0;
  localparam logic [2:0] REG_SCORE_MIN = 3'd1;
  localparam logic [2:0] REG_SIZES     = 3'd2;
  localparam logic [2:0] REG_MAX       = 3'd3;
  localparam logic [2:0] REG_CTRL      = 3'd4;
  localparam logic [2:0] REG_RESULT    = 3'd5;
  localparam logic [2:0] REG_FLAGS     = 3'd6;

  localparam int BUSY_B = 0;
  localparam int DONE_B = 1;
  localparam int ERR_B  = 2;

  localparam int CTRL_COMPRESS_B = 0;
  localparam int CTRL_IRQ_EN_B   = 1;

  // Fields sized to the widest value the 32-bit bus can carry; the top trims to parameters.
  typedef struct packed {
    logic [15:0] sector;
    logic [15:0] len;
    logic [7:0]  score_min;
    logic [14:0] sample_size;
    logic [7:0]  packet_size;
    logic [31:0] max;
    logic        compress;
    logic        irq_en;
  } chan_cfg_t;

endpackage

// File: rtl/ai_av_channel_regs.sv
// One comparer channel: configuration registers, busy/done/err flags, result latch and init pulse.
// CTRL bit1 (irq_en) is only writable when AI_AV_IRQ_EN is defined.
module ai_av_channel_regs
  import ai_av_pkg::*;
#(
  parameter int MAX_W   = 24,
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [2:0]         reg_idx,
  input  logic [31:0]        wdata,
  input  logic               done_i,
  input  logic [SCORE_W-1:0] score_i,
  output chan_cfg_t          cfg,
  output logic               init,
  output logic               irq_req,
  output logic [31:0]        rd_data
);

  chan_cfg_t          cfg_q, cfg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               init_q, init_d;
  logic [SCORE_W-1:0] result_q, result_d;

  // Completion is applied first so a START accepted in the same cycle still leaves busy set,
  // while a W1C of done never beats a same-cycle completion.
  always_comb begin
    cfg_d    = cfg_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    result_d = result_q;
    init_d   = 1'b0;

    if (done_i) begin
      busy_d   = 1'b0;
      done_d   = 1'b1;
      result_d = score_i;
    end

    if (wr_en) begin
      case (reg_idx)
        REG_START: begin
          if (!busy_q) begin
            cfg_d.sector = wdata[31:16];
            cfg_d.len    = wdata[15:0];
            busy_d       = 1'b1;
            init_d       = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        REG_SCORE_MIN: cfg_d.score_min = wdata[7:0];
        REG_SIZES: begin
          cfg_d.sample_size = wdata[14:0];
          cfg_d.packet_size = wdata[23:16];
        end
        REG_MAX: begin
          cfg_d.max            = '0;
          cfg_d.max[MAX_W-1:0] = wdata[MAX_W-1:0];
        end
        REG_CTRL: begin
          cfg_d.compress = wdata[CTRL_COMPRESS_B];
`ifdef AI_AV_IRQ_EN
          cfg_d.irq_en   = wdata[CTRL_IRQ_EN_B];
`endif
        end
        REG_FLAGS: begin
          if (wdata[DONE_B] && !done_i) done_d = 1'b0;
          if (wdata[ERR_B]) err_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      init_q   <= 1'b0;
      result_q <= '0;
    end else begin
      cfg_q    <= cfg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      init_q   <= init_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_START, REG_FLAGS: begin
        rd_data[BUSY_B] = busy_q;
        rd_data[DONE_B] = done_q;
        rd_data[ERR_B]  = err_q;
      end
      REG_SCORE_MIN: rd_data[7:0] = cfg_q.score_min;
      REG_SIZES:     rd_data[23:0] = {cfg_q.packet_size, 1'b0, cfg_q.sample_size};
      REG_MAX:       rd_data = cfg_q.max;
      REG_CTRL: begin
        rd_data[CTRL_COMPRESS_B] = cfg_q.compress;
        rd_data[CTRL_IRQ_EN_B]   = cfg_q.irq_en;
      end
      REG_RESULT:    rd_data[SCORE_W-1:0] = result_q;
      default: ;
    endcase
  end

  assign cfg     = cfg_q;
  assign init    = init_q;
  assign irq_req = done_q & cfg_q.irq_en;

endmodule

// File: rtl/ai_av_regfile.sv
// Avalon-MM register file configuring CHANNELS comparer engines, with 1-cycle registered reads.
// Optional AI_AV_IRQ_EN adds a registered irq output.
module ai_av_regfile
  import ai_av_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 6,
  parameter int SECTOR_W = 16,
  parameter int MAX_W    = 24,
  parameter int SCORE_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         avs_s0_write,
  input  logic                         avs_s0_read,
  input  logic [ADDR_W-1:0]            avs_s0_address,
  input  logic [31:0]                  avs_s0_writedata,
  output logic [31:0]                  avs_s0_readdata,
  output logic                         avs_s0_readdatavalid,
  output logic [CHANNELS-1:0]          init,
  output logic [CHANNELS*SECTOR_W-1:0] load_sector,
  output logic [CHANNELS*SECTOR_W-1:0] load_len,
  output logic [CHANNELS*8-1:0]        score_minimum,
  output logic [CHANNELS*15-1:0]       sample_size,
  output logic [CHANNELS*8-1:0]        packet_size,
  output logic [CHANNELS*MAX_W-1:0]    max,
  output logic [CHANNELS-1:0]          compress,
  input  logic [CHANNELS-1:0]          done_i,
  input  logic [CHANNELS*SCORE_W-1:0]  score_i
`ifdef AI_AV_IRQ_EN
  ,
  output logic                         irq
`endif
);

  logic [ADDR_W-4:0]   ch_idx;
  logic [2:0]          reg_idx;
  chan_cfg_t           cfg [CHANNELS];
  logic [31:0]         ch_rd [CHANNELS];
  logic [CHANNELS-1:0] irq_req;
  logic [CHANNELS-1:0] unused_bits;
  logic [31:0]         rd_mux;
  logic [31:0]         readdata_q, readdata_d;
  logic                rdv_q, rdv_d;

  assign ch_idx  = avs_s0_address[ADDR_W-1:3];
  assign reg_idx = avs_s0_address[2:0];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    ai_av_channel_regs #(
      .MAX_W   (MAX_W),
      .SCORE_W (SCORE_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (avs_s0_write && (32'(ch_idx) == c)),
      .reg_idx (reg_idx),
      .wdata   (avs_s0_writedata),
      .done_i  (done_i[c]),
      .score_i (score_i[c*SCORE_W +: SCORE_W]),
      .cfg     (cfg[c]),
      .init    (init[c]),
      .irq_req (irq_req[c]),
      .rd_data (ch_rd[c])
    );

    assign load_sector[c*SECTOR_W +: SECTOR_W] = cfg[c].sector[SECTOR_W-1:0];
    assign load_len[c*SECTOR_W +: SECTOR_W]    = cfg[c].len[SECTOR_W-1:0];
    assign score_minimum[c*8 +: 8]             = cfg[c].score_min;
    assign sample_size[c*15 +: 15]             = cfg[c].sample_size;
    assign packet_size[c*8 +: 8]               = cfg[c].packet_size;
    assign max[c*MAX_W +: MAX_W]               = cfg[c].max[MAX_W-1:0];
    assign compress[c]                         = cfg[c].compress;
    assign unused_bits[c] = ^{cfg[c].sector, cfg[c].len, cfg[c].max, cfg[c].irq_en, irq_req[c]};
  end

  // Out-of-range channel indices match no bank and fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (32'(ch_idx) == c) rd_mux = ch_rd[c];
    end
    readdata_d = avs_s0_read ? rd_mux : readdata_q;
    rdv_d      = avs_s0_read;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readdata_q <= '0;
      rdv_q      <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      rdv_q      <= rdv_d;
    end
  end

  assign avs_s0_readdata      = readdata_q;
  assign avs_s0_readdatavalid = rdv_q;

`ifdef AI_AV_IRQ_EN
  logic irq_q, irq_d;

  always_comb irq_d = |irq_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_ai_av_regfile.sv
// Randomised self-checking bench for ai_av_regfile against a per-channel behavioural model.
// Build with +define+AI_AV_IRQ_EN to also check the irq output.
module tb_ai_av_regfile;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          avs_s0_write = 1'b0;
  logic          avs_s0_read = 1'b0;
  logic [5:0]    avs_s0_address = '0;
  logic [31:0]   avs_s0_writedata = '0;
  logic [31:0]   avs_s0_readdata;
  logic          avs_s0_readdatavalid;
  logic [3:0]    init;
  logic [63:0]   load_sector, load_len;
  logic [31:0]   score_minimum, packet_size;
  logic [59:0]   sample_size;
  logic [95:0]   max;
  logic [3:0]    compress;
  logic [3:0]    done_i = '0;
  logic [63:0]   score_i = '0;
`ifdef AI_AV_IRQ_EN
  logic          irq;
`endif

  int vectors = 0;
  int miscompares = 0;

  bit [15:0] m_sector [CH], m_len [CH], m_result [CH];
  bit [7:0]  m_smin [CH], m_packet [CH];
  bit [14:0] m_sample [CH];
  bit [23:0] m_max [CH];
  bit        m_comp [CH], m_irqen [CH], m_busy [CH], m_done [CH], m_err [CH];

  ai_av_regfile dut (
    .clk                  (clk),
    .rst                  (rst),
    .avs_s0_write         (avs_s0_write),
    .avs_s0_read          (avs_s0_read),
    .avs_s0_address       (avs_s0_address),
    .avs_s0_writedata     (avs_s0_writedata),
    .avs_s0_readdata      (avs_s0_readdata),
    .avs_s0_readdatavalid (avs_s0_readdatavalid),
    .init                 (init),
    .load_sector          (load_sector),
    .load_len             (load_len),
    .score_minimum        (score_minimum),
    .sample_size          (sample_size),
    .packet_size          (packet_size),
    .max                  (max),
    .compress             (compress),
    .done_i               (done_i),
    .score_i              (score_i)
`ifdef AI_AV_IRQ_EN
    ,
    .irq                  (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] modelRead(input bit [5:0] addr);
    int ch = int'(addr[5:3]);
    int r  = int'(addr[2:0]);
    if (ch >= CH) return 32'd0;
    case (r)
      0, 6: return {29'd0, m_err[ch], m_done[ch], m_busy[ch]};
      1: return {24'd0, m_smin[ch]};
      2: return {8'd0, m_packet[ch], 1'b0, m_sample[ch]};
      3: return {8'd0, m_max[ch]};
      4: return {30'd0, m_irqen[ch], m_comp[ch]};
      5: return {16'd0, m_result[ch]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void modelReset();
    for (int c = 0; c < CH; c++) begin
      m_sector[c] = 0; m_len[c] = 0; m_result[c] = 0; m_smin[c] = 0; m_packet[c] = 0;
      m_sample[c] = 0; m_max[c] = 0; m_comp[c] = 0; m_irqen[c] = 0;
      m_busy[c] = 0; m_done[c] = 0; m_err[c] = 0;
    end
  endfunction

  task automatic checkConfig();
    logic [63:0] e_sec, e_len;
    logic [31:0] e_smin, e_pkt;
    logic [59:0] e_smp;
    logic [95:0] e_max;
    logic [3:0]  e_cmp;
    for (int c = 0; c < CH; c++) begin
      e_sec[c*16 +: 16] = m_sector[c];
      e_len[c*16 +: 16] = m_len[c];
      e_smin[c*8 +: 8]  = m_smin[c];
      e_pkt[c*8 +: 8]   = m_packet[c];
      e_smp[c*15 +: 15] = m_sample[c];
      e_max[c*24 +: 24] = m_max[c];
      e_cmp[c]          = m_comp[c];
    end
    checkOutput("load_sector", 128'(load_sector), 128'(e_sec));
    checkOutput("load_len", 128'(load_len), 128'(e_len));
    checkOutput("score_minimum", 128'(score_minimum), 128'(e_smin));
    checkOutput("packet_size", 128'(packet_size), 128'(e_pkt));
    checkOutput("sample_size", 128'(sample_size), 128'(e_smp));
    checkOutput("max", 128'(max), 128'(e_max));
    checkOutput("compress", 128'(compress), 128'(e_cmp));
  endtask

  // One bus cycle: drive, predict from the pre-edge model state, clock, then check.
  task automatic applyStimulus(input bit wr, input bit rd, input bit [5:0] addr,
                               input bit [31:0] wd, input bit [3:0] dn, input bit [63:0] sc);
    bit [31:0] exp_rd;
    bit [3:0]  exp_init = '0;
    bit        exp_irq = 1'b0;
    bit        started [CH];
    int        ch = int'(addr[5:3]);
    int        r  = int'(addr[2:0]);

    avs_s0_write = wr; avs_s0_read = rd; avs_s0_address = addr;
    avs_s0_writedata = wd; done_i = dn; score_i = sc;

    exp_rd = modelRead(addr);
    for (int c = 0; c < CH; c++) begin
      exp_irq |= m_done[c] & m_irqen[c];
      started[c] = 1'b0;
    end

    if (wr && ch < CH) begin
      case (r)
        0: if (!m_busy[ch]) begin
             m_sector[ch] = wd[31:16]; m_len[ch] = wd[15:0];
             m_busy[ch] = 1; started[ch] = 1; exp_init[ch] = 1;
           end else m_err[ch] = 1;
        1: m_smin[ch] = wd[7:0];
        2: begin m_sample[ch] = wd[14:0]; m_packet[ch] = wd[23:16]; end
        3: m_max[ch] = wd[23:0];
        4: begin
             m_comp[ch] = wd[0];
`ifdef AI_AV_IRQ_EN
             m_irqen[ch] = wd[1];
`endif
           end
        6: begin
             if (wd[1]) m_done[ch] = 0;
             if (wd[2]) m_err[ch] = 0;
           end
        default: ;
      endcase
    end
    for (int c = 0; c < CH; c++) begin
      if (dn[c]) begin
        m_done[c] = 1;
        m_result[c] = sc[c*16 +: 16];
        if (!started[c]) m_busy[c] = 0;
      end
    end

    @(posedge clk);
    #1;
    checkOutput("readdatavalid", 128'(avs_s0_readdatavalid), 128'(rd));
    if (rd) checkOutput("readdata", 128'(avs_s0_readdata), 128'(exp_rd));
    checkOutput("init", 128'(init), 128'(exp_init));
`ifdef AI_AV_IRQ_EN
    checkOutput("irq", 128'(irq), 128'(exp_irq));
`endif
    checkConfig();
    avs_s0_write = 0; avs_s0_read = 0; done_i = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #2;
    modelReset();
    checkOutput("rst_readdatavalid", 128'(avs_s0_readdatavalid), 128'd0);
    checkOutput("rst_readdata", 128'(avs_s0_readdata), 128'd0);
    checkOutput("rst_init", 128'(init), 128'd0);
`ifdef AI_AV_IRQ_EN
    checkOutput("rst_irq", 128'(irq), 128'd0);
`endif
    checkConfig();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic bit [5:0] randAddr();
    bit [2:0] ch = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
    return {ch, 3'($urandom_range(0, 7))};
  endfunction

  initial begin
    bit [5:0]  a;
    bit [31:0] d;
    bit [3:0]  dn;

    modelReset();
    repeat (2) @(posedge clk);
    #1;
    doReset();

    for (int r = 0; r < 7; r++) applyStimulus(0, 1, 6'(r), 0, 0, 0);

    applyStimulus(1, 0, 6'h10, 32'h0012_0040, 0, 0);
    applyStimulus(0, 1, 6'h10, 0, 0, 0);
    applyStimulus(1, 0, 6'h10, 32'h0099_0001, 0, 0);
    applyStimulus(0, 1, 6'h10, 0, 0, 0);
    applyStimulus(0, 0, 6'h00, 0, 4'b0100, 64'h0000_1234_0000_0000);
    applyStimulus(0, 1, 6'h10, 0, 0, 0);
    applyStimulus(0, 1, 6'h15, 0, 0, 0);
    applyStimulus(1, 0, 6'h16, 32'h6, 0, 0);
    applyStimulus(0, 1, 6'h10, 0, 0, 0);
    applyStimulus(1, 1, 6'h0A, 32'h0020_7FFF, 0, 0);
    applyStimulus(0, 1, 6'h0A, 0, 0, 0);
    applyStimulus(1, 0, 6'h2B, 32'hFFFF_FFFF, 0, 0);
    applyStimulus(0, 1, 6'h2B, 0, 0, 0);
    applyStimulus(1, 0, 6'h1C, 32'h3, 0, 0);
    applyStimulus(0, 0, 6'h00, 0, 4'b1000, 64'h5A5A_0000_0000_0000);
    applyStimulus(0, 0, 6'h00, 0, 0, 0);
    applyStimulus(1, 0, 6'h1E, 32'h2, 0, 0);
    applyStimulus(0, 0, 6'h00, 0, 0, 0);
    applyStimulus(0, 1, 6'h1D, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      if (i == 300) doReset();
      a  = randAddr();
      d  = $urandom();
      dn = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a, d, dn,
                    {$urandom(), $urandom()});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
